// File: rtl/sysreg_arbiter_if.sv
// Request/response and star-bus signals around sysreg_arbiter.
// slave is the arbiter's view; master is the requesters plus the star-bus dispatcher.
interface sysreg_arbiter_if #(
  parameter int REG_WIDTH = 64,
  parameter int NR_REQ    = 2
);
  localparam int IDW = $clog2(NR_REQ);

  logic [NR_REQ-1:0]           req_valid;
  logic [NR_REQ-1:0]           req_ready;
  logic [NR_REQ-1:0]           req_write;
  logic [NR_REQ*5-1:0]         req_group;
  logic [NR_REQ*3-1:0]         req_regnum;
  logic [NR_REQ*2-1:0]         req_plevel;
  logic [NR_REQ*REG_WIDTH-1:0] req_wdata;

  logic                        resp_valid;
  logic                        resp_ready;
  logic [IDW-1:0]              resp_id;
  logic [REG_WIDTH-1:0]        resp_data;
  logic                        resp_err;

  logic                        rd_en;
  logic [4:0]                  rd_group;
  logic [2:0]                  rd_regnum;
  logic [1:0]                  rd_plevel;
  logic                        rd_valid;
  logic [REG_WIDTH-1:0]        rd_val;

  logic                        wr_en;
  logic [4:0]                  wr_group;
  logic [2:0]                  wr_regnum;
  logic [1:0]                  wr_plevel;
  logic [REG_WIDTH-1:0]        wr_val;

  modport slave (
    input  req_valid, req_write, req_group, req_regnum, req_plevel, req_wdata,
    input  resp_ready, rd_valid, rd_val,
    output req_ready, resp_valid, resp_id, resp_data, resp_err,
    output rd_en, rd_group, rd_regnum, rd_plevel,
    output wr_en, wr_group, wr_regnum, wr_plevel, wr_val
  );

  modport master (
    output req_valid, req_write, req_group, req_regnum, req_plevel, req_wdata,
    output resp_ready, rd_valid, rd_val,
    input  req_ready, resp_valid, resp_id, resp_data, resp_err,
    input  rd_en, rd_group, rd_regnum, rd_plevel,
    input  wr_en, wr_group, wr_regnum, wr_plevel, wr_val
  );
endinterface

// File: rtl/sysreg_arbiter.sv
// Round-robin arbiter sharing the system-register star bus between NR_REQ requesters.
// One access in flight at a time; a read with no return ends in an error response.
module sysreg_arbiter #(
  parameter int REG_WIDTH = 64,
  parameter int NR_REQ    = 2,
  parameter int TIMEOUT   = 16
) (
  input  logic            clk,
  input  logic            rst,
  sysreg_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NR_REQ);
  localparam int CW  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RD_WAIT  = 2'd1,
    S_WR_ISSUE = 2'd2,
    S_RESP     = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [IDW-1:0]       r_last_grant;
  logic [IDW-1:0]       r_id;
  logic [CW-1:0]        r_cnt;
  logic [4:0]           r_group;
  logic [2:0]           r_regnum;
  logic [1:0]           r_plevel;
  logic [REG_WIDTH-1:0] r_wdata;
  logic [REG_WIDTH-1:0] r_resp_data;
  logic                 r_resp_err;

  logic                 w_found;
  logic                 w_hit;
  logic [IDW-1:0]       w_win;
  logic [NR_REQ-1:0]    w_req_ready;
  logic                 w_rd_en;
  logic                 w_wr_en;
  logic                 w_resp_valid;
  logic                 w_rd_done;

  // Round-robin search starting one past the last grant.
  always_comb begin
    w_found = 1'b0;
    w_hit   = 1'b0;
    w_win   = '0;
    for (int k = 1; k <= NR_REQ; k++) begin
      w_hit   = bus.req_valid[(int'(r_last_grant) + k) % NR_REQ] & ~w_found;
      w_win   = w_hit ? IDW'((int'(r_last_grant) + k) % NR_REQ) : w_win;
      w_found = w_found | w_hit;
    end
  end

  assign w_rd_done = bus.rd_valid || (r_cnt == CW'(TIMEOUT - 1));

  // Next-state decode and per-state outputs.
  always_comb begin
    w_next       = r_state;
    w_req_ready  = '0;
    w_rd_en      = 1'b0;
    w_wr_en      = 1'b0;
    w_resp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found && rst) begin
          // rst gating keeps req_ready low while reset is held
          w_req_ready = {{(NR_REQ-1){1'b0}}, 1'b1} << w_win;
          w_next      = bus.req_write[w_win] ? S_WR_ISSUE : S_RD_WAIT;
        end else begin
          w_next      = S_IDLE;
        end
      end
      S_RD_WAIT: begin
        w_rd_en = 1'b1;
        if (w_rd_done) begin
          w_next = S_RESP;
        end else begin
          w_next = S_RD_WAIT;
        end
      end
      S_WR_ISSUE: begin
        w_wr_en = 1'b1;
        w_next  = S_RESP;
      end
      S_RESP: begin
        w_resp_valid = 1'b1;
        if (bus.resp_ready) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_RESP;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Request capture, timeout counter and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant <= IDW'(NR_REQ - 1);
      r_id         <= '0;
      r_cnt        <= '0;
      r_group      <= 5'd0;
      r_regnum     <= 3'd0;
      r_plevel     <= 2'd0;
      r_wdata      <= '0;
      r_resp_data  <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_last_grant <= w_win;
            r_id         <= w_win;
            r_cnt        <= '0;
            r_group      <= bus.req_group[int'(w_win)*5 +: 5];
            r_regnum     <= bus.req_regnum[int'(w_win)*3 +: 3];
            r_plevel     <= bus.req_plevel[int'(w_win)*2 +: 2];
            r_wdata      <= bus.req_wdata[int'(w_win)*REG_WIDTH +: REG_WIDTH];
          end
        end
        S_RD_WAIT: begin
          if (bus.rd_valid) begin
            r_resp_data <= bus.rd_val;
            r_resp_err  <= 1'b0;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_resp_data <= '0;
            r_resp_err  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_WR_ISSUE: begin
          r_resp_data <= '0;
          r_resp_err  <= 1'b0;
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.resp_valid = w_resp_valid;
  assign bus.resp_id    = r_id;
  assign bus.resp_data  = r_resp_data;
  assign bus.resp_err   = r_resp_err;
  assign bus.rd_en      = w_rd_en;
  assign bus.rd_group   = r_group;
  assign bus.rd_regnum  = r_regnum;
  assign bus.rd_plevel  = r_plevel;
  assign bus.wr_en      = w_wr_en;
  assign bus.wr_group   = r_group;
  assign bus.wr_regnum  = r_regnum;
  assign bus.wr_plevel  = r_plevel;
  assign bus.wr_val     = r_wdata;
endmodule

// File: tb/tb_sysreg_arbiter.sv
// Bench for sysreg_arbiter: directed scenarios then random accesses, each checked
// against a transaction-level model of round-robin grant, latency and response.
module tb_sysreg_arbiter;
  localparam int RW = 64;
  localparam int NR = 2;
  localparam int TO = 16;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   last_grant;

  logic          t_write [NR];
  logic [4:0]    t_group [NR];
  logic [2:0]    t_reg   [NR];
  logic [1:0]    t_pl    [NR];
  logic [RW-1:0] t_wdata [NR];

  sysreg_arbiter_if #(.REG_WIDTH(RW), .NR_REQ(NR)) bus ();

  sysreg_arbiter #(.REG_WIDTH(RW), .NR_REQ(NR), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input int lg, input logic [NR-1:0] m);
    for (int d = 1; d <= NR; d++) begin
      if (m[(lg + d) % NR]) return (lg + d) % NR;
    end
    return -1;
  endfunction

  task automatic rand_fields(input int i);
    t_write[i] = 1'($urandom);
    t_group[i] = 5'($urandom);
    t_reg[i]   = 3'($urandom);
    t_pl[i]    = 2'($urandom);
    t_wdata[i] = {$urandom, $urandom};
  endtask

  task automatic drive_fields();
    for (int i = 0; i < NR; i++) begin
      bus.req_write[i]          = t_write[i];
      bus.req_group[5*i +: 5]   = t_group[i];
      bus.req_regnum[3*i +: 3]  = t_reg[i];
      bus.req_plevel[2*i +: 2]  = t_pl[i];
      bus.req_wdata[RW*i +: RW] = t_wdata[i];
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},  64'(bus.req_ready),  64'd0);
    check({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'd0);
    check({tag, "_resp_id"},    64'(bus.resp_id),    64'd0);
    check({tag, "_resp_data"},  64'(bus.resp_data),  64'd0);
    check({tag, "_resp_err"},   64'(bus.resp_err),   64'd0);
    check({tag, "_rd_en"},      64'(bus.rd_en),      64'd0);
    check({tag, "_wr_en"},      64'(bus.wr_en),      64'd0);
    check({tag, "_bus_fields"}, 64'({bus.rd_group, bus.rd_regnum, bus.rd_plevel,
                                     bus.wr_group, bus.wr_regnum, bus.wr_plevel}), 64'd0);
    check({tag, "_wr_val"},     64'(bus.wr_val),     64'd0);
  endtask

  // One access: k is the read-return cycle after acceptance (0 = never), hold the
  // number of cycles resp_ready stays low. gnt is the grant seen on req_ready.
  task automatic access(input logic [NR-1:0] m, input int k, input logic [RW-1:0] rv,
                        input int hold, output int gnt, output logic [NR-1:0] rest);
    int            w;
    int            last_j;
    logic [RW-1:0] exp_data;
    logic          exp_err;
    w = rr_pick(last_grant, m);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    bus.rd_valid   = 1'b0;
    bus.req_valid  = m;
    drive_fields();
    #1;
    check("grant_req_ready", 64'(bus.req_ready), 64'd1 << w);
    check("grant_no_resp", 64'(bus.resp_valid), 64'd0);
    check("grant_no_cmd", 64'({bus.rd_en, bus.wr_en}), 64'd0);
    gnt = -1;
    for (int i = 0; i < NR; i++) begin
      if (bus.req_ready[i]) gnt = i;
    end
    last_grant = w;
    rest = m & ~(NR'(1) << w);
    if (t_write[w]) begin
      @(negedge clk);
      bus.req_valid = rest;
      #1;
      check("wr_en", 64'(bus.wr_en), 64'd1);
      check("wr_rd_en", 64'(bus.rd_en), 64'd0);
      check("wr_fields", 64'({bus.wr_group, bus.wr_regnum, bus.wr_plevel}),
            64'({t_group[w], t_reg[w], t_pl[w]}));
      check("wr_val", 64'(bus.wr_val), 64'(t_wdata[w]));
      check("wr_busy", 64'({bus.resp_valid, bus.req_ready}), 64'd0);
      exp_data = '0;
      exp_err  = 1'b0;
    end else begin
      last_j = (k == 0) ? TO : k;
      for (int j = 1; j <= last_j; j++) begin
        @(negedge clk);
        bus.req_valid = rest;
        bus.rd_valid  = (j == k);
        bus.rd_val    = (j == k) ? rv : {$urandom, $urandom};
        #1;
        check("rd_en", 64'(bus.rd_en), 64'd1);
        check("rd_fields", 64'({bus.rd_group, bus.rd_regnum, bus.rd_plevel}),
              64'({t_group[w], t_reg[w], t_pl[w]}));
        check("rd_busy", 64'({bus.wr_en, bus.resp_valid, bus.req_ready}), 64'd0);
      end
      exp_data = (k == 0) ? '0 : rv;
      exp_err  = (k == 0);
    end
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      bus.rd_valid   = 1'b0;
      bus.req_valid  = rest;
      bus.resp_ready = (h == hold);
      #1;
      check("resp_valid", 64'(bus.resp_valid), 64'd1);
      check("resp_id", 64'(bus.resp_id), 64'(w));
      check("resp_data", 64'(bus.resp_data), 64'(exp_data));
      check("resp_err", 64'(bus.resp_err), 64'(exp_err));
      check("resp_quiet", 64'({bus.rd_en, bus.wr_en, bus.req_ready}), 64'd0);
    end
  endtask

  initial begin
    int              gnt;
    int              prev;
    int              k;
    int              hold;
    logic [NR-1:0]   m;
    logic [NR-1:0]   rest;

    rst = 1'b0;
    bus.req_valid  = '0;
    bus.resp_ready = 1'b0;
    bus.rd_valid   = 1'b0;
    bus.rd_val     = '0;
    for (int i = 0; i < NR; i++) begin
      t_write[i] = 1'b0; t_group[i] = 5'd0; t_reg[i] = 3'd0; t_pl[i] = 2'd0; t_wdata[i] = '0;
    end
    drive_fields();
    last_grant = NR - 1;

    @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;

    // Read from requester 0, return on the second rd_en cycle.
    t_write[0] = 1'b0; t_group[0] = 5'd10; t_reg[0] = 3'd3; t_pl[0] = 2'd1;
    access(2'b01, 2, 64'hDEAD_BEEF, 0, gnt, rest);

    // Write from requester 1.
    t_write[1] = 1'b1; t_group[1] = 5'd10; t_reg[1] = 3'd5; t_pl[1] = 2'd0;
    t_wdata[1] = 64'h1234;
    access(2'b10, 0, 64'd0, 0, gnt, rest);
    prev = gnt;

    // Both requesters pending continuously: grants must alternate.
    rand_fields(0);
    rand_fields(1);
    for (int n = 0; n < 8; n++) begin
      access(2'b11, int'($urandom_range(1, 4)), {$urandom, $urandom}, 0, gnt, rest);
      check("rr_alternate", 64'(gnt != prev), 64'd1);
      prev = gnt;
      if (gnt >= 0) rand_fields(gnt);
    end

    // Timeout, then a late return that must be ignored.
    t_write[0] = 1'b0;
    access(2'b01, 0, 64'd0, 0, gnt, rest);
    @(negedge clk);
    bus.req_valid = '0;
    bus.resp_ready = 1'b0;
    bus.rd_valid = 1'b1;
    bus.rd_val = {$urandom, $urandom};
    #1;
    check("late_rd_idle", 64'({bus.rd_en, bus.resp_valid}), 64'd0);
    @(negedge clk);
    bus.rd_valid = 1'b0;
    #1;
    check("late_rd_no_resp", 64'(bus.resp_valid), 64'd0);

    // Response back-pressure with another requester waiting.
    rand_fields(0); rand_fields(1);
    t_write[0] = 1'b0; t_write[1] = 1'b0;
    access(2'b11, 3, {$urandom, $urandom}, 5, gnt, rest);
    access(rest, 1, {$urandom, $urandom}, 0, gnt, rest);

    // Asynchronous reset in the middle of a read.
    rand_fields(0); rand_fields(1);
    t_write[0] = 1'b0;
    drive_fields();
    @(negedge clk);
    bus.req_valid = 2'b01;
    bus.resp_ready = 1'b0;
    #1;
    check("rst_pre_grant", 64'(bus.req_ready), 64'd1 << rr_pick(last_grant, 2'b01));
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      bus.req_valid = 2'b10;
      #1;
      check("rst_pre_rd_en", 64'(bus.rd_en), 64'd1);
    end
    bus.req_valid = 2'b11;
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    #1;
    check_reset_outputs("rst_hold");
    bus.req_valid = 2'b00;
    rst = 1'b1;
    last_grant = NR - 1;
    access(2'b11, 2, {$urandom, $urandom}, 0, gnt, rest);
    check("rst_rr_restart", 64'(gnt), 64'd0);

    // Random traffic.
    rest = '0;
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (!rest[i]) rand_fields(i);
      end
      m = rest | NR'($urandom);
      if (m == '0) m = NR'(1) << $urandom_range(0, NR - 1);
      k = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TO));
      hold = int'($urandom_range(0, 3));
      access(m, k, {$urandom, $urandom}, hold, gnt, rest);
    end

    @(negedge clk);
    bus.req_valid = '0;
    bus.resp_ready = 1'b0;
    #1;
    check("final_idle", 64'({bus.rd_en, bus.wr_en, bus.resp_valid}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
